ssd_scan_driver: RTL
====================

# ssd_scan_driver

Time-multiplexed four-digit seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures the converter's hundreds/tens/ones BCD digits plus a sign flag, double-buffers them so a display frame never tears, and scans the digits onto a common-anode display. Scanning uses a programmable refresh prescaler. The block also provides leading-zero blanking and shows an error glyph for non-BCD nibbles.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit; legal range is at least 2.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `hundreds`  input  4  BCD hundreds digit from the converter.
- `tens`  input  4  BCD tens digit.
- `ones`  input  4  BCD ones digit.
- `neg`  input  1  sign flag; 1 shows a minus on digit 3.
- `load`  input  1  single-cycle strobe; captures `hundreds`/`tens`/`ones`/`neg` into the pending buffer.
- `blank_en`  input  1  enables leading-zero blanking.
- `an`  output  4  digit enables, active-low; `an[0]` is the rightmost digit (ones).
- `seg`  output  7  segment drive, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  output  1  decimal point, active-low; held at 1 (off).

## Operation
- **Prescaler**
  - `div_cnt` counts 0..REFRESH_DIV-1 and wraps.
  - `tick` = (`div_cnt` == REFRESH_DIV-1).
- **Digit index**
  - `idx` (2 bits) advances on `tick`: 0→1→2→3→0.
  - Frame boundary = `tick` while `idx`==3.
- **Buffering**
  - `load` writes the pending registers (P_h, P_t, P_o, P_n).
  - At a frame boundary, the pending registers copy into the display registers (D_h, D_t, D_o, D_n).
  - If `load` coincides with a frame boundary, the display registers take the live inputs directly, and pending takes them too.
  - Multiple loads within a frame: the last one wins.
- **Digit mapping**
  - `idx` 0 → D_o.
  - `idx` 1 → D_t.
  - `idx` 2 → D_h.
  - `idx` 3 → sign: minus (7'b0111111) if D_n, else blank (7'b1111111).
- **Blanking** (only when `blank_en`=1)
  - Hundreds is blank if D_h==0.
  - Tens is blank if D_h==0 and D_t==0.
  - Ones is never blanked.
  - A blanked digit keeps its `an` bit low and drives `seg`=7'b1111111.
- **Decode**, as `seg[6:0]`:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - 10–15: "E" 0000110
  - The error glyph overrides blanking: a non-BCD hundreds digit is never blanked.
- `an` = one-hot-low of `idx`.

## Timing
- **Reset** (asynchronous, immediate):
  - `div_cnt`=0, `idx`=0.
  - Pending and display registers all 0.
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
- `an`/`seg` are registered: they reflect `idx` and the display registers as sampled at the previous edge, giving one cycle of latency.
- **First edge after reset release:**
  - `an`=4'b1110, `seg`=1000000 (ones = 0).
  - `blank_en` does not affect this digit.
- Each digit is lit for exactly REFRESH_DIV cycles; a frame is 4×REFRESH_DIV cycles.
- **Load-to-display latency:** the new value appears on `an`/`seg` one cycle after the next frame boundary. The worst case is 4×REFRESH_DIV+1 cycles after `load`.
- **Reset asserted mid-scan:** all state clears in the same cycle, and pending data is discarded. Scanning restarts at `idx` 0 with a full REFRESH_DIV dwell.
- `blank_en`, being unbuffered, takes effect on the next edge.
- `div_cnt` width is ceil(log2(REFRESH_DIV)); no overflow beyond REFRESH_DIV-1.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `an`=1111, `seg`=1111111, `dp`=1 immediately. Release → next edge `an`=1110, `seg`=1000000.
- **Scan order** (REFRESH_DIV=4):
  - Load h=1, t=2, o=3, neg=1, then wait one frame.
  - Each `an` pattern must hold exactly 4 cycles, with the following `seg` values:
    - `an`=1110: `seg`=0110000
    - `an`=1101: `seg`=0100100
    - `an`=1011: `seg`=1111001
    - `an`=0111: `seg`=0111111
  - Sequence then repeats.
- **Blanking:** load 0,0,7, `neg`=0, `blank_en`=1.
  - Digits 3, 2 and 1 show `seg`=1111111 with their `an` bits still low.
  - Ones shows 1111000.
  - With `blank_en`=0, hundreds and tens show 1000000.
- **Tear-free update:**
  - `load` 4,5,6 while `idx`=1.
  - The remainder of the frame still shows the old digits.
  - New digits appear from the first `an`=1110 after the boundary.
  - Also cover `load` on the exact boundary cycle: the new values must appear immediately in the next frame.
- **Invalid BCD:** load hundreds=12, tens=0, `blank_en`=1 → hundreds shows 0000110 (not blanked); tens shows 1000000.
- **Reset mid-operation:**
  - Pulse `rst` while `idx`=2 with a load pending.
  - Display registers and pending registers read 0, and scanning restarts at `an`=1110.
  - The pending value is never shown.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with double-buffered BCD digits,
// sign glyph, leading-zero blanking and an error glyph for non-BCD nibbles.
module ssd_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_hundreds,
   input  logic [3:0] i_tens,
   input  logic [3:0] i_ones,
   input  logic       i_neg,
   input  logic       i_load,
   input  logic       i_blank_en,
   output logic [3:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   logic [CNT_W-1:0] r_div_cnt;
   logic [1:0]       r_idx;
   logic [3:0]       r_ph, r_pt, r_po;
   logic             r_pn;
   logic [3:0]       r_dh, r_dt, r_do;
   logic             r_dn;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;

   logic             w_tick;
   logic             w_frame;
   logic             w_blank_h;
   logic             w_blank_t;
   logic [3:0]       w_an_nxt;
   logic [6:0]       w_seg_nxt;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0000110;
      endcase
      return s;
   endfunction

   // Non-BCD hundreds is never zero, so the error glyph naturally wins over blanking.
   always_comb begin
      w_tick    = (r_div_cnt == CNT_LAST);
      w_frame   = w_tick && (r_idx == 2'd3);
      w_blank_h = i_blank_en && (r_dh == 4'd0);
      w_blank_t = w_blank_h && (r_dt == 4'd0);
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = SEG_BLANK;
      case (r_idx)
         2'd0:    w_seg_nxt = f_decode(r_do);
         2'd1:    w_seg_nxt = w_blank_t ? SEG_BLANK : f_decode(r_dt);
         2'd2:    w_seg_nxt = w_blank_h ? SEG_BLANK : f_decode(r_dh);
         default: w_seg_nxt = r_dn ? SEG_MINUS : SEG_BLANK;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_cnt <= '0;
         r_idx     <= 2'd0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
         r_idx     <= r_idx + 2'd1;
      end else begin
         r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
   end

   // Pending buffer takes every load; display copies at the frame boundary only.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ph <= 4'd0;
         r_pt <= 4'd0;
         r_po <= 4'd0;
         r_pn <= 1'b0;
         r_dh <= 4'd0;
         r_dt <= 4'd0;
         r_do <= 4'd0;
         r_dn <= 1'b0;
      end else begin
         if (i_load) begin
            r_ph <= i_hundreds;
            r_pt <= i_tens;
            r_po <= i_ones;
            r_pn <= i_neg;
         end
         if (w_frame) begin
            r_dh <= i_load ? i_hundreds : r_ph;
            r_dt <= i_load ? i_tens     : r_pt;
            r_do <= i_load ? i_ones     : r_po;
            r_dn <= i_load ? i_neg      : r_pn;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_an  <= 4'b1111;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= 1'b1;
      end
   end

   assign o_an  = r_an;
   assign o_seg = r_seg;
   assign o_dp  = r_dp;

endmodule
